tsc_leak_rx: RTL and testbench

TSC_LEAK_RX -- requirements
Module: tsc_leak_rx

---
 rtl/tsc_leak_rx.sv | 142 ++++++++++++++
 tb/tb_tsc_leak_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tsc_leak_rx.sv
// Leakage-channel key receiver: reassembles two 64-bit words into a 128-bit key.
// Optional macro TSC_LEAK_RX_DESCRAMBLE_EN enables the 64-bit LFSR descrambler.
module tsc_leak_rx #(
  parameter logic [63:0] LFSR_SEED = 64'hACE1_ACE1_ACE1_ACE1,
  parameter logic [15:0] TIMEOUT   = 16'd1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  cap_in,
  input  logic         cap_valid,
  output logic [127:0] key_out,
  output logic         key_valid,
  input  logic         key_ack,
  output logic         sync_err,
  output logic [7:0]   overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALF1 = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic           key_valid_q, key_valid_d;
  logic           sync_err_q, sync_err_d;
  logic [7:0]     overrun_q, overrun_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [15:0]    cnt_inc;
  logic [63:0]    word;
  logic           timeout_hit;

  assign cnt_inc     = cnt_q + 16'd1;
  assign timeout_hit = (state_q == HALF1) && !cap_valid && (cnt_inc >= TIMEOUT);

`ifdef TSC_LEAK_RX_DESCRAMBLE_EN
  localparam logic [63:0] SEED_EFF = (LFSR_SEED == 64'd0) ? 64'd1 : LFSR_SEED;

  logic [63:0] lfsr_q, lfsr_d;
  logic        accept;

  function automatic logic [63:0] lfsr_next(input logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction

  assign word   = cap_in ^ lfsr_q;
  // A word is consumed in IDLE/HALF1, or in HOLD only when the key is acked alongside it.
  assign accept = cap_valid && ((state_q == IDLE) || (state_q == HALF1) ||
                                ((state_q == HOLD) && key_ack));

  always_comb begin
    lfsr_d = lfsr_q;
    if (timeout_hit) lfsr_d = SEED_EFF;
    else if (accept) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED_EFF;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign word = cap_in;

  // The seed has no effect without the descrambler.
  if (LFSR_SEED == 64'd0) begin : g_seed_unused
  end
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    sync_err_d  = 1'b0;
    overrun_d   = overrun_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cap_valid) begin
          key_d[127:64] = word;
          cnt_d         = 16'd0;
          state_d       = HALF1;
        end
      end
      HALF1: begin
        if (cap_valid) begin
          key_d[63:0] = word;
          key_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (timeout_hit) begin
          sync_err_d = 1'b1;
          cnt_d      = 16'd0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLD: begin
        if (key_ack) begin
          key_valid_d = 1'b0;
          if (cap_valid) begin
            key_d[127:64] = word;
            cnt_d         = 16'd0;
            state_d       = HALF1;
          end else begin
            state_d = IDLE;
          end
        end else if (cap_valid && (overrun_q != 8'hFF)) begin
          overrun_d = overrun_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      overrun_q   <= 8'd0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      sync_err_q  <= sync_err_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
    end
  end

  assign key_out     = key_q;
  assign key_valid   = key_valid_q;
  assign sync_err    = sync_err_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_tsc_leak_rx.sv
// Scoreboard bench for tsc_leak_rx: stimulus pushes expected keys, a monitor pops
// them on each rising key_valid; directed checks cover reset, timeout and overrun.
module tb_tsc_leak_rx;

  localparam logic [63:0] SEED = 64'hACE1_ACE1_ACE1_ACE1;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  cap_in;
  logic         cap_valid;
  logic [127:0] key_out;
  logic         key_valid;
  logic         key_ack;
  logic         sync_err;
  logic [7:0]   overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_keys   = 0;
  int sync_pulses = 0;
  logic kv_prev = 1'b0;
  logic [127:0] exp_q[$];
  logic [63:0]  model_lfsr = SEED;

  tsc_leak_rx dut (
    .clk(clk), .rst(rst), .cap_in(cap_in), .cap_valid(cap_valid),
    .key_out(key_out), .key_valid(key_valid), .key_ack(key_ack),
    .sync_err(sync_err), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected descrambled value of an accepted word; advances the reference LFSR.
  task automatic take(input logic [63:0] w, output logic [63:0] e);
`ifdef TSC_LEAK_RX_DESCRAMBLE_EN
    e = w ^ model_lfsr;
    model_lfsr = {model_lfsr[62:0], model_lfsr[63] ^ model_lfsr[62] ^ model_lfsr[60] ^ model_lfsr[59]};
`else
    e = w;
`endif
  endtask

  task automatic drive(input logic v, input logic [63:0] w, input logic ack);
    @(posedge clk);
    #1;
    cap_valid = v;
    cap_in    = w;
    key_ack   = ack;
  endtask

  task automatic send_frame(input logic [63:0] hi, input logic [63:0] lo);
    logic [63:0] eh, el;
    take(hi, eh);
    take(lo, el);
    exp_q.push_back({eh, el});
    drive(1'b1, hi, 1'b0);
    drive(1'b1, lo, 1'b0);
    drive(1'b0, 64'd0, 1'b0);
  endtask

  task automatic ack_key();
    drive(1'b0, 64'd0, 1'b1);
    drive(1'b0, 64'd0, 1'b0);
  endtask

  // Monitor: pops the scoreboard on each new key and watches sync_err.
  initial begin
    forever begin
      @(negedge clk);
      if (key_valid && sync_err) check("kv_and_sync_err", 128'd1, 128'd0);
      if (sync_err) sync_pulses++;
      if (key_valid && !kv_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL key_unexpected: got %h expected none", key_out);
        end else begin
          check("key_scoreboard", key_out, exp_q.pop_front());
          n_keys++;
        end
      end
      kv_prev = key_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  w_a, w_b, ej, ek, tmp;
    logic [127:0] exp_first, held;

    rst = 1'b1; cap_valid = 1'b0; cap_in = '0; key_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_key_out", key_out, '0);
    check("rst_key_valid", {127'd0, key_valid}, 128'd0);
    check("rst_sync_err", {127'd0, sync_err}, 128'd0);
    check("rst_overrun", {120'd0, overrun_cnt}, 128'd0);
    rst = 1'b0;

    // Basic frame with hand-computed vectors.
`ifdef TSC_LEAK_RX_DESCRAMBLE_EN
    w_a = 64'hACE1_ACE1_ACE1_ACE1;
    w_b = 64'h59C3_59C3_59C3_59C2;
    exp_first = 128'd0;
`else
    w_a = 64'h0011_2233_4455_6677;
    w_b = 64'h8899_AABB_CCDD_EEFF;
    exp_first = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
`endif
    take(w_a, tmp);
    take(w_b, tmp);
    exp_q.push_back(exp_first);
    drive(1'b1, w_a, 1'b0);
    drive(1'b1, w_b, 1'b0);
    drive(1'b0, 64'd0, 1'b0);
    check("latency_key_valid", {127'd0, key_valid}, 128'd1);
    drive(1'b0, 64'd0, 1'b0);
    check("hold_key_valid", {127'd0, key_valid}, 128'd1);
    ack_key();
    check("ack_deasserts", {127'd0, key_valid}, 128'd0);

    // Half frame then TIMEOUT idle cycles.
    take(64'h1234_5678_9ABC_DEF0, tmp);
    drive(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0);
    drive(1'b0, 64'd0, 1'b0);
    repeat (1023) @(posedge clk);
    #1;
    check("no_early_sync_err", {127'd0, sync_err}, 128'd0);
    @(posedge clk); #1;
    check("sync_err_pulse", {127'd0, sync_err}, 128'd1);
    check("no_kv_on_timeout", {127'd0, key_valid}, 128'd0);
    @(posedge clk); #1;
    check("sync_err_one_cycle", {127'd0, sync_err}, 128'd0);
    model_lfsr = SEED;
    send_frame(64'hCAFE_BABE_0000_1111, 64'hFEED_FACE_2222_3333);
    check("post_timeout_kv", {127'd0, key_valid}, 128'd1);
    ack_key();

    // Overrun: 300 words while a key is held.
    send_frame(64'h0F0F_0F0F_F0F0_F0F0, 64'h5555_AAAA_3333_CCCC);
    held = key_out;
    for (int i = 0; i < 300; i++) drive(1'b1, 64'hDEAD_0000_0000_0000 + 64'(i), 1'b0);
    drive(1'b0, 64'd0, 1'b0);
    check("overrun_saturate", {120'd0, overrun_cnt}, 128'd255);
    check("overrun_key_stable", key_out, held);
    check("overrun_kv_held", {127'd0, key_valid}, 128'd1);
    ack_key();
    send_frame(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
    check("lfsr_not_advanced_kv", {127'd0, key_valid}, 128'd1);

    // Ack and new upper half in the same cycle.
    take(64'h0123_4567_89AB_CDEF, ej);
    drive(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
    drive(1'b0, 64'd0, 1'b0);
    check("ack_with_word_kv", {127'd0, key_valid}, 128'd0);
    check("ack_with_word_upper", {64'd0, key_out[127:64]}, {64'd0, ej});
    take(64'hFEDC_BA98_7654_3210, ek);
    exp_q.push_back({ej, ek});
    drive(1'b1, 64'hFEDC_BA98_7654_3210, 1'b0);
    drive(1'b0, 64'd0, 1'b0);
    check("ack_with_word_frame_kv", {127'd0, key_valid}, 128'd1);
    ack_key();

    // Reset while in HALF1.
    drive(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    drive(1'b0, 64'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_key_out", key_out, '0);
    check("midrst_key_valid", {127'd0, key_valid}, 128'd0);
    check("midrst_sync_err", {127'd0, sync_err}, 128'd0);
    check("midrst_overrun", {120'd0, overrun_cnt}, 128'd0);
    rst = 1'b0;
    model_lfsr = SEED;
    send_frame(64'h9999_8888_7777_6666, 64'h4444_3333_2222_1111);
    check("post_rst_kv", {127'd0, key_valid}, 128'd1);
    ack_key();

    repeat (3) @(posedge clk);
    #1;
    check("sync_err_total", 128'(sync_pulses), 128'd1);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    check("keys_seen", 128'(n_keys), 128'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
